// File: rtl/scalar_writeback_if.sv
// Load-result stream into the scalar writeback block: valid/ready handshake
// carrying the destination register and the loaded data.
interface scalar_writeback_if #(
    parameter int DW = 32
);
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rd;
    logic [DW-1:0] mem_data;

    modport master (
        output mem_valid,
        output mem_rd,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_rd,
        input  mem_data,
        output mem_ready
    );
endinterface

// File: rtl/scalar_writeback.sv
// Scalar register-file writer: ALU results win the single write port, load results
// queue in a FIFO, and a pending-load scoreboard drives the decode stall.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding outputs for decode.
module scalar_writeback #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 15,
    parameter int DW       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [DW-1:0]              alu_data,
    scalar_writeback_if.slave          mem,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    input  logic [4:0]                 Rs1,
    input  logic [4:0]                 Rs2,
    input  logic                       rs1_used,
    input  logic                       rs2_used,
    output logic                       stall,
    output logic                       WriteEn,
    output logic [4:0]                 rd,
    output logic [DW-1:0]              InputData,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       waw_err
`ifdef WB_BYPASS_EN
    ,
    output logic                       fwd1_hit,
    output logic                       fwd2_hit,
    output logic [DW-1:0]              fwd1_data,
    output logic [DW-1:0]              fwd2_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [5:0] NREGS6 = 6'(NUM_REGS);

    logic [4:0]          fifo_rd   [DEPTH];
    logic [DW-1:0]       fifo_data [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [4:0]          head_rd;
    logic [DW-1:0]       head_data;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                alu_hits_pending;

    function automatic logic in_range(input logic [4:0] r);
        return {1'b0, r} < NREGS6;
    endfunction

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign mem.mem_ready = !full && !rst;
    assign push          = mem.mem_valid && mem.mem_ready;
    // ALU traffic owns the write port, so the queue only drains on ALU-idle cycles.
    assign pop           = !alu_valid && !empty;
    assign head_rd       = fifo_rd[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];
    assign q_count       = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mem.mem_rd;
            fifo_data[wr_ptr] <= mem.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clear for the popped load is applied before the issue set, so a same-cycle set wins.
    always_comb begin
        stall            = 1'b0;
        alu_hits_pending = 1'b0;
        pending_next     = pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs1_used && Rs1 == 5'(i) && pending[i])
                stall = 1'b1;
            if (rs2_used && Rs2 == 5'(i) && pending[i])
                stall = 1'b1;
            if (alu_valid && alu_rd == 5'(i) && pending[i])
                alu_hits_pending = 1'b1;
            if (pop && head_rd == 5'(i))
                pending_next[i] = 1'b0;
            if (issue_valid && issue_rd == 5'(i))
                pending_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WriteEn   <= 1'b0;
            rd        <= '0;
            InputData <= '0;
            waw_err   <= 1'b0;
            pending   <= '0;
        end else begin
            waw_err <= alu_hits_pending;
            pending <= pending_next;
            if (alu_valid) begin
                WriteEn   <= in_range(alu_rd);
                rd        <= alu_rd;
                InputData <= alu_data;
            end else if (pop) begin
                WriteEn   <= in_range(head_rd);
                rd        <= head_rd;
                InputData <= head_data;
            end else begin
                WriteEn   <= 1'b0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = WriteEn && (rd == Rs1);
    assign fwd2_hit  = WriteEn && (rd == Rs2);
    assign fwd1_data = InputData;
    assign fwd2_data = InputData;
`endif

endmodule

// File: tb/tb_scalar_writeback.sv
// Self-checking bench for scalar_writeback: directed scenarios plus a randomized run
// compared against a queue-based model of the writeback rules.
module tb_scalar_writeback;

    localparam int DEPTH    = 4;
    localparam int NUM_REGS = 15;
    localparam int DW       = 32;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [DW-1:0] alu_data;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    Rs1;
    logic [4:0]    Rs2;
    logic          rs1_used;
    logic          rs2_used;
    logic          stall;
    logic          WriteEn;
    logic [4:0]    rd;
    logic [DW-1:0] InputData;
    logic [2:0]    q_count;
    logic          waw_err;
`ifdef WB_BYPASS_EN
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [DW-1:0] fwd1_data;
    logic [DW-1:0] fwd2_data;
`endif

    int checks   = 0;
    int failures = 0;

    ent_t          q[$];
    bit            pend_m[32];
    logic          exp_we;
    logic [4:0]    exp_rd;
    logic [DW-1:0] exp_data;
    logic          exp_waw;

    scalar_writeback_if #(.DW(DW)) mif ();

    scalar_writeback #(
        .DEPTH(DEPTH),
        .NUM_REGS(NUM_REGS),
        .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .mem(mif),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .Rs1(Rs1),
        .Rs2(Rs2),
        .rs1_used(rs1_used),
        .rs2_used(rs2_used),
        .stall(stall),
        .WriteEn(WriteEn),
        .rd(rd),
        .InputData(InputData),
        .q_count(q_count),
        .waw_err(waw_err)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_hit(fwd1_hit),
        .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data),
        .fwd2_data(fwd2_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        mif.mem_valid = 1'b0;
        mif.mem_rd    = '0;
        mif.mem_data  = '0;
        issue_valid   = 1'b0;
        issue_rd      = '0;
        Rs1           = '0;
        Rs2           = '0;
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;
    endtask

    function automatic bit model_stall();
        return (rs1_used && pend_m[Rs1]) || (rs2_used && pend_m[Rs2]);
    endfunction

    // Advances the reference model by one clock using the inputs currently driven,
    // then moves to 1 time unit past the rising edge.
    task automatic tick();
        ent_t e;
        bit   do_push;
        if (rst) begin
            q.delete();
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            exp_we   = 1'b0;
            exp_rd   = '0;
            exp_data = '0;
            exp_waw  = 1'b0;
        end else begin
            do_push = mif.mem_valid && (q.size() < DEPTH);
            exp_waw = alu_valid && (alu_rd < NUM_REGS) && pend_m[alu_rd];
            if (alu_valid) begin
                exp_we   = (alu_rd < NUM_REGS);
                exp_rd   = alu_rd;
                exp_data = alu_data;
            end else if (q.size() > 0) begin
                e        = q.pop_front();
                exp_we   = (e.rd < NUM_REGS);
                exp_rd   = e.rd;
                exp_data = e.data;
                if (e.rd < NUM_REGS) pend_m[e.rd] = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            if (issue_valid && issue_rd < NUM_REGS) pend_m[issue_rd] = 1'b1;
            if (do_push) q.push_back('{mif.mem_rd, mif.mem_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (mif.mem_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_low: got %b expected 0", mif.mem_ready);
        end
        tick();
        tick();
        checks++;
        if (WriteEn !== 1'b0 || rd !== 5'd0 || InputData !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_write_port: got we=%b rd=%0d data=%h expected 0/0/0", WriteEn, rd, InputData);
        end
        checks++;
        if (q_count !== 3'd0 || waw_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_count_waw: got q_count=%0d waw=%b expected 0/0", q_count, waw_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mif.mem_ready !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_ready_stall: got ready=%b stall=%b expected 1/0", mif.mem_ready, stall);
        end
        tick();
        checks++;
        if (WriteEn !== 1'b0 || q_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got we=%b q_count=%0d expected 0/0", WriteEn, q_count);
        end
    endtask

    task automatic test_alu_write();
        idle();
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (WriteEn !== 1'b1 || rd !== 5'd3 || InputData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL alu_write: got we=%b rd=%0d data=%h expected 1/3/deadbeef", WriteEn, rd, InputData);
        end
        idle();
        tick();
        checks++;
        if (WriteEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_write_drop: got we=%b expected 0", WriteEn);
        end
    endtask

    task automatic test_load_hazard();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        issue_valid = 1'b0;
        Rs1         = 5'd5;
        rs1_used    = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hazard_stall: got %b expected 1", stall);
        end
        mif.mem_valid = 1'b1;
        mif.mem_rd    = 5'd5;
        mif.mem_data  = 32'h55;
        tick();
        mif.mem_valid = 1'b0;
        checks++;
        if (WriteEn !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_latency_n1: got we=%b stall=%b expected 0/1", WriteEn, stall);
        end
        tick();
        checks++;
        if (WriteEn !== 1'b1 || rd !== 5'd5 || InputData !== 32'h55) begin
            failures++;
            $display("[TB] FAIL load_write: got we=%b rd=%0d data=%h expected 1/5/55", WriteEn, rd, InputData);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hazard_release: got %b expected 0", stall);
        end
    endtask

    task automatic test_fifo_full();
        logic [4:0]    saved_rd   [DEPTH];
        logic [DW-1:0] saved_data [DEPTH];
        idle();
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        for (int i = 0; i < DEPTH; i++) begin
            saved_rd[i]   = 5'(8 + i);
            saved_data[i] = $urandom;
            mif.mem_valid = 1'b1;
            mif.mem_rd    = saved_rd[i];
            mif.mem_data  = saved_data[i];
            alu_data      = $urandom;
            tick();
            checks++;
            if (WriteEn !== 1'b1 || rd !== 5'd1 || InputData !== alu_data) begin
                failures++;
                $display("[TB] FAIL full_alu_priority: got we=%b rd=%0d data=%h expected 1/1/%h", WriteEn, rd, InputData, alu_data);
            end
        end
        mif.mem_rd   = 5'd9;
        mif.mem_data = 32'hBAD0_0000;
        #1;
        checks++;
        if (mif.mem_ready !== 1'b0 || q_count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL full_state: got ready=%b q_count=%0d expected 0/4", mif.mem_ready, q_count);
        end
        tick();
        checks++;
        if (q_count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL full_reject: got q_count=%0d expected 4", q_count);
        end
        mif.mem_valid = 1'b0;
        alu_valid     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if (WriteEn !== 1'b1 || rd !== saved_rd[i] || InputData !== saved_data[i]) begin
                failures++;
                $display("[TB] FAIL drain_order_%0d: got we=%b rd=%0d data=%h expected 1/%0d/%h", i, WriteEn, rd, InputData, saved_rd[i], saved_data[i]);
            end
        end
        tick();
        checks++;
        if (WriteEn !== 1'b0 || q_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL drain_empty: got we=%b q_count=%0d expected 0/0", WriteEn, q_count);
        end
    endtask

    task automatic test_set_wins();
        idle();
        mif.mem_valid = 1'b1;
        mif.mem_rd    = 5'd7;
        mif.mem_data  = 32'h77;
        tick();
        mif.mem_valid = 1'b0;
        issue_valid   = 1'b1;
        issue_rd      = 5'd7;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (WriteEn !== 1'b1 || rd !== 5'd7) begin
            failures++;
            $display("[TB] FAIL setwins_pop: got we=%b rd=%0d expected 1/7", WriteEn, rd);
        end
        Rs1      = 5'd7;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL setwins_pending: got stall=%b expected 1", stall);
        end
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = $urandom;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (waw_err !== 1'b1 || WriteEn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL waw_pulse: got waw=%b we=%b expected 1/1", waw_err, WriteEn);
        end
        tick();
        checks++;
        if (waw_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL waw_one_cycle: got %b expected 0", waw_err);
        end
        mif.mem_valid = 1'b1;
        tick();
        mif.mem_valid = 1'b0;
        tick();
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL setwins_clear: got stall=%b expected 0", stall);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        alu_valid     = 1'b1;
        alu_rd        = 5'd2;
        issue_valid   = 1'b1;
        issue_rd      = 5'd4;
        mif.mem_valid = 1'b1;
        mif.mem_rd    = 5'd4;
        mif.mem_data  = $urandom;
        tick();
        issue_valid   = 1'b0;
        mif.mem_rd    = 5'd6;
        mif.mem_data  = $urandom;
        tick();
        checks++;
        if (q_count !== 3'd2) begin
            failures++;
            $display("[TB] FAIL midreset_prefill: got q_count=%0d expected 2", q_count);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (q_count !== 3'd0 || WriteEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_flush: got q_count=%0d we=%b expected 0/0", q_count, WriteEn);
        end
        Rs1      = 5'd4;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_pending: got stall=%b expected 0", stall);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (WriteEn !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_no_write_%0d: got we=%b expected 0", i, WriteEn);
            end
        end
        mif.mem_valid = 1'b1;
        mif.mem_rd    = 5'd15;
        mif.mem_data  = 32'hF00D;
        tick();
        mif.mem_valid = 1'b0;
        checks++;
        if (q_count !== 3'd1) begin
            failures++;
            $display("[TB] FAIL oor_push: got q_count=%0d expected 1", q_count);
        end
        tick();
        checks++;
        if (WriteEn !== 1'b0 || q_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL oor_pop: got we=%b q_count=%0d expected 0/0", WriteEn, q_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 49) == 0);
            alu_valid     = ($urandom_range(0, 9) < 3);
            alu_rd        = 5'($urandom_range(0, 17));
            alu_data      = $urandom;
            mif.mem_valid = ($urandom_range(0, 1) == 1);
            mif.mem_rd    = 5'($urandom_range(0, 17));
            mif.mem_data  = $urandom;
            issue_valid   = ($urandom_range(0, 3) == 0);
            issue_rd      = 5'($urandom_range(0, 17));
            Rs1           = 5'($urandom_range(0, 17));
            Rs2           = 5'($urandom_range(0, 17));
            rs1_used      = ($urandom_range(0, 1) == 1);
            rs2_used      = ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (mif.mem_ready !== (!rst && q.size() < DEPTH) || stall !== model_stall()) begin
                failures++;
                $display("[TB] FAIL rand_comb_%0d: got ready=%b stall=%b expected %b/%b", c, mif.mem_ready, stall, (!rst && q.size() < DEPTH), model_stall());
            end
            tick();
            checks++;
            if (WriteEn !== exp_we || waw_err !== exp_waw || q_count !== 3'(q.size())
                || (exp_we && (rd !== exp_rd || InputData !== exp_data))) begin
                failures++;
                $display("[TB] FAIL rand_write_%0d: got we=%b rd=%0d data=%h waw=%b cnt=%0d expected %b/%0d/%h/%b/%0d",
                         c, WriteEn, rd, InputData, waw_err, q_count, exp_we, exp_rd, exp_data, exp_waw, q.size());
            end
`ifdef WB_BYPASS_EN
            checks++;
            if (fwd1_hit !== (exp_we && exp_rd == Rs1) || (fwd1_hit && fwd1_data !== exp_data)) begin
                failures++;
                $display("[TB] FAIL rand_fwd_%0d: got hit=%b data=%h expected %b/%h", c, fwd1_hit, fwd1_data, (exp_we && exp_rd == Rs1), exp_data);
            end
`endif
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_alu_write();
        test_load_hazard();
        test_fifo_full();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
